iq_push_sequencer: RTL and testbench
====================================

// Module: iq_push_sequencer
// PURPOSE
//  Sits between the instruction decoder and the superscalar instruction queue (IQ) push port.
//  Accepts one decoded instruction with a repeat count, splits it into IQ pushes of at most
//  MAX_GROUP copies, and advances the base addresses per group. When the IQ reports that its
//  virtual-array read position has saturated (iq_needs_reset), it stops pushing, drains the IQ
//  and execution pipes, pulses iq_reset, and then resumes the interrupted instruction.
// PARAMETERS
//  MAX_GROUP      16  max copies per IQ push; equals IQ superscalar width; power of 2
//  RESET_CYCLES   2   cycles iq_reset is held high during a refresh (>=1)
//  SETTLE_CYCLES  2   consecutive cycles iq_empty&&exec_idle must hold before reset (>=1)
// PORTS
//  clk                 in   1   clock
//  reset               in   1   synchronous, active-high
//  in_valid            in   1   decoder offers an instruction
//  in_ready            out  1   sequencer accepts (high only in IDLE)
//  in_instr_type       in   2   RAM / LOAD_STORE / ARITHMETIC encoding, as used by the IQ
//  in_repeat           in   8   copies to issue; 0 = no-op
//  in_op               in   9   opcode bits; IQ uses [8:0] arith, [6:0] ld/st, [2:0] ram
//  in_cache_addr       in   11  base cache address of copy 0
//  in_d_cache_addr     in   11  cache address stride per copy
//  in_main_mem_addr    in   7   base main-memory address of copy 0
//  in_d_main_mem_addr  in   7   main-memory stride per copy
//  iq_we               out  1   push strobe to IQ
//  iq_instr_type       out  2   latched type
//  iq_copy_count       out  5   copies in this push, 1..MAX_GROUP
//  iq_op               out  9   latched opcode
//  iq_cache_addr       out  11  base cache address of this group
//  iq_d_cache_addr     out  11  latched stride
//  iq_main_mem_addr    out  7   base main-memory address of this group
//  iq_d_main_mem_addr  out  7   latched stride
//  iq_stall_push       in   1   IQ almost full; no push this cycle
//  iq_needs_reset      in   1   IQ read position saturated
//  iq_empty            in   1   IQ has nothing left to pop
//  exec_idle           in   1   all execution pipes drained
//  iq_reset            out  1   reset to IQ; ORed with global reset at the top level
//  busy                out  1   state != IDLE
// BEHAVIOUR
//  - States: IDLE, ISSUE, DRAIN, REFRESH. On reset: IDLE; remaining=0; all latched fields 0;
//    iq_we=0, iq_reset=0, in_ready=1, busy=0.
//  - IDLE: in_ready=1. in_valid with iq_needs_reset=0 latches all in_* fields and sets
//    remaining=in_repeat. Next state is ISSUE if in_repeat!=0, otherwise IDLE.
//    If iq_needs_reset=1 in IDLE, in_ready=0 and the next state is DRAIN.
//  - ISSUE: iq_we = !iq_stall_push && !iq_needs_reset (combinational).
//    iq_copy_count = min(remaining, MAX_GROUP).
//  - On each push: cur_cache += d_cache*copy_count (mod 2^11); cur_mem += d_mem*copy_count
//    (mod 2^7); remaining -= copy_count.
//  - When remaining reaches 0, next state is IDLE. The first push occurs the cycle after
//    acceptance. Group addresses are registered and valid whenever iq_we=1.
//  - While stalled, the outputs hold and nothing advances.
//  - iq_needs_reset in ISSUE: no push that cycle, next state is DRAIN, and remaining and
//    address state are preserved.
//  - DRAIN: iq_we=0. A counter increments while iq_empty&&exec_idle and clears otherwise.
//    At SETTLE_CYCLES, next state is REFRESH.
//  - REFRESH: iq_reset=1 for exactly RESET_CYCLES cycles, then ISSUE if remaining!=0,
//    else IDLE. iq_needs_reset is ignored during REFRESH.
//  - iq_reset is registered and glitch-free. iq_we is never high while iq_reset is high or
//    in DRAIN.
//  - Global reset mid-operation aborts everything immediately and returns to IDLE; the
//    partial instruction is dropped.
// TESTING
//  - repeat=40, stride cache 3, mem 1, base 100/5, no stall -> pushes (16,100,5) (16,148,21)
//    (8,196,37); in_ready high again on the 4th cycle after acceptance.
//  - repeat=20, stall high for 3 cycles during the 2nd push -> outputs held, 2nd push
//    (count 4) lands after the stall drops; no duplicate push.
//  - needs_reset after the 1st of 3 groups; empty&&idle 2 cycles later -> DRAIN waits,
//    iq_reset high 2 cycles, then groups 2 and 3 issue with the correct continued addresses.
//  - cache base 2040 + stride 1, repeat=16 -> a single push at 2040; next base wraps to 8;
//    repeat=0 -> no iq_we, in_ready back next cycle.
//  - global reset asserted mid-ISSUE -> next cycle IDLE, iq_we=0, iq_reset=0, in_ready=1.

Source files
------------

// File: rtl/iq_push_sequencer.sv
// iq_push_sequencer
//   Sits between the instruction decoder and the superscalar instruction queue
//   push port. It accepts one decoded instruction with a repeat count and
//   splits it into IQ pushes of at most MAX_GROUP copies. The base addresses
//   advance by stride*copies after every group. When the IQ reports that its
//   read position has saturated, the sequencer stops pushing and waits for the
//   IQ and the execution pipes to drain. It then pulses iq_reset and resumes
//   the interrupted instruction.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   in_valid / in_ready   decoder handshake (ready only in IDLE)
//   in_instr_type, in_repeat, in_op, in_cache_addr, in_d_cache_addr,
//   in_main_mem_addr, in_d_main_mem_addr
//                         decoded instruction fields
//   iq_we                 push strobe to the IQ
//   iq_instr_type, iq_copy_count, iq_op, iq_cache_addr, iq_d_cache_addr,
//   iq_main_mem_addr, iq_d_main_mem_addr
//                         push payload for the current group
//   iq_stall_push         IQ almost full, hold this cycle
//   iq_needs_reset        IQ read position saturated
//   iq_empty, exec_idle   drain status used before refreshing the IQ
//   iq_reset              registered reset pulse to the IQ
//   busy                  sequencer not in IDLE
module iq_push_sequencer #(
  parameter int MAX_GROUP     = 16,
  parameter int RESET_CYCLES  = 2,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_instr_type,
  input  logic [7:0]  in_repeat,
  input  logic [8:0]  in_op,
  input  logic [10:0] in_cache_addr,
  input  logic [10:0] in_d_cache_addr,
  input  logic [6:0]  in_main_mem_addr,
  input  logic [6:0]  in_d_main_mem_addr,
  output logic        iq_we,
  output logic [1:0]  iq_instr_type,
  output logic [4:0]  iq_copy_count,
  output logic [8:0]  iq_op,
  output logic [10:0] iq_cache_addr,
  output logic [10:0] iq_d_cache_addr,
  output logic [6:0]  iq_main_mem_addr,
  output logic [6:0]  iq_d_main_mem_addr,
  input  logic        iq_stall_push,
  input  logic        iq_needs_reset,
  input  logic        iq_empty,
  input  logic        exec_idle,
  output logic        iq_reset,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    DRAIN   = 2'd2,
    REFRESH = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  remaining_q;
  logic [1:0]  type_q;
  logic [8:0]  op_q;
  logic [10:0] cur_cache_q;
  logic [10:0] d_cache_q;
  logic [6:0]  cur_mem_q;
  logic [6:0]  d_mem_q;
  logic [7:0]  settle_q;
  logic [7:0]  refresh_q;
  logic        iq_reset_q;
  logic        accept;
  logic        quiet;
  logic [10:0] cache_step;
  logic [6:0]  mem_step;

  // The current group is the smaller of what is left and one full IQ row.
  assign iq_copy_count = (remaining_q > 8'(MAX_GROUP)) ? 5'(MAX_GROUP) : remaining_q[4:0];

  // Address advance per group. The products wrap naturally at the field widths.
  assign cache_step = d_cache_q * 11'(iq_copy_count);
  assign mem_step   = d_mem_q * 7'(iq_copy_count);

  assign quiet = iq_empty && exec_idle;

  assign iq_instr_type      = type_q;
  assign iq_op              = op_q;
  assign iq_cache_addr      = cur_cache_q;
  assign iq_d_cache_addr    = d_cache_q;
  assign iq_main_mem_addr   = cur_mem_q;
  assign iq_d_main_mem_addr = d_mem_q;
  assign iq_reset           = iq_reset_q;
  assign busy               = (state_q != IDLE);

  // Next-state and handshake logic. A saturated IQ takes priority over new
  // work and over pushing. Stalls simply hold the state.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    accept   = 1'b0;
    iq_we    = 1'b0;
    case (state_q)
      IDLE: begin
        if (iq_needs_reset) begin
          state_d = DRAIN;
        end else begin
          in_ready = 1'b1;
          if (in_valid) begin
            accept = 1'b1;
            if (in_repeat != 8'd0) state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (iq_needs_reset) begin
          state_d = DRAIN;
        end else if (!iq_stall_push) begin
          iq_we = 1'b1;
          if (remaining_q == 8'(iq_copy_count)) state_d = IDLE;
        end
      end
      DRAIN: begin
        if (quiet && settle_q == 8'(SETTLE_CYCLES - 1)) state_d = REFRESH;
      end
      REFRESH: begin
        if (refresh_q == 8'(RESET_CYCLES - 1))
          state_d = (remaining_q != 8'd0) ? ISSUE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and counter registers. iq_reset is registered from the next state,
  // so it is high for exactly the cycles spent in REFRESH and cannot glitch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      settle_q   <= 8'd0;
      refresh_q  <= 8'd0;
      iq_reset_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      settle_q   <= (state_q == DRAIN && state_d == DRAIN && quiet) ? settle_q + 8'd1 : 8'd0;
      refresh_q  <= (state_q == REFRESH && state_d == REFRESH) ? refresh_q + 8'd1 : 8'd0;
      iq_reset_q <= (state_d == REFRESH);
    end
  end

  // Instruction fields are captured on acceptance. The group base addresses
  // and the remaining count advance only on an actual push.
  always_ff @(posedge clk) begin
    if (reset) begin
      remaining_q <= 8'd0;
      type_q      <= 2'd0;
      op_q        <= 9'd0;
      cur_cache_q <= 11'd0;
      d_cache_q   <= 11'd0;
      cur_mem_q   <= 7'd0;
      d_mem_q     <= 7'd0;
    end else if (accept) begin
      remaining_q <= in_repeat;
      type_q      <= in_instr_type;
      op_q        <= in_op;
      cur_cache_q <= in_cache_addr;
      d_cache_q   <= in_d_cache_addr;
      cur_mem_q   <= in_main_mem_addr;
      d_mem_q     <= in_d_main_mem_addr;
    end else if (iq_we) begin
      remaining_q <= remaining_q - 8'(iq_copy_count);
      cur_cache_q <= cur_cache_q + cache_step;
      cur_mem_q   <= cur_mem_q + mem_step;
    end
  end

endmodule

// File: tb/tb_iq_push_sequencer.sv
// tb_iq_push_sequencer
//   Directed bench for iq_push_sequencer. Each accepted instruction queues its
//   expected IQ pushes. A monitor pops one entry per iq_we and compares the
//   entry with the payload the design presents.
module tb_iq_push_sequencer;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_instr_type;
  logic [7:0]  in_repeat;
  logic [8:0]  in_op;
  logic [10:0] in_cache_addr;
  logic [10:0] in_d_cache_addr;
  logic [6:0]  in_main_mem_addr;
  logic [6:0]  in_d_main_mem_addr;
  logic        iq_we;
  logic [1:0]  iq_instr_type;
  logic [4:0]  iq_copy_count;
  logic [8:0]  iq_op;
  logic [10:0] iq_cache_addr;
  logic [10:0] iq_d_cache_addr;
  logic [6:0]  iq_main_mem_addr;
  logic [6:0]  iq_d_main_mem_addr;
  logic        iq_stall_push;
  logic        iq_needs_reset;
  logic        iq_empty;
  logic        exec_idle;
  logic        iq_reset;
  logic        busy;

  typedef struct {
    logic [4:0]  cnt;
    logic [10:0] cache;
    logic [6:0]  mem;
    logic [8:0]  op;
    logic [1:0]  typ;
  } push_t;

  push_t sb[$];
  push_t mp;
  int total = 0;
  int bad   = 0;
  int high_cycles;

  iq_push_sequencer dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr_type(in_instr_type), .in_repeat(in_repeat), .in_op(in_op),
    .in_cache_addr(in_cache_addr), .in_d_cache_addr(in_d_cache_addr),
    .in_main_mem_addr(in_main_mem_addr), .in_d_main_mem_addr(in_d_main_mem_addr),
    .iq_we(iq_we), .iq_instr_type(iq_instr_type), .iq_copy_count(iq_copy_count),
    .iq_op(iq_op), .iq_cache_addr(iq_cache_addr), .iq_d_cache_addr(iq_d_cache_addr),
    .iq_main_mem_addr(iq_main_mem_addr), .iq_d_main_mem_addr(iq_d_main_mem_addr),
    .iq_stall_push(iq_stall_push), .iq_needs_reset(iq_needs_reset),
    .iq_empty(iq_empty), .exec_idle(exec_idle),
    .iq_reset(iq_reset), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue the pushes this instruction should produce, then offer it for one cycle.
  task automatic applyStimulus(input logic [1:0] t, input int rep, input logic [8:0] op,
                               input int cache, input int dc, input int mem, input int dm);
    int issued;
    push_t p;
    issued = 0;
    while (issued < rep) begin
      int n;
      n = (rep - issued > 16) ? 16 : rep - issued;
      p.cnt   = 5'(n);
      p.cache = 11'((cache + dc * issued) % 2048);
      p.mem   = 7'((mem + dm * issued) % 128);
      p.op    = op;
      p.typ   = t;
      sb.push_back(p);
      issued += n;
    end
    in_valid           = 1'b1;
    in_instr_type      = t;
    in_repeat          = 8'(rep);
    in_op              = op;
    in_cache_addr      = 11'(cache);
    in_d_cache_addr    = 11'(dc);
    in_main_mem_addr   = 7'(mem);
    in_d_main_mem_addr = 7'(dm);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (in_ready && !busy) break;
    end
    checkOutput(name, int'(in_ready && !busy), 1);
    tick();
  endtask

  // Monitor: every push the design makes must match the next expected group.
  always @(negedge clk) begin
    if (!reset && iq_we) begin
      checkOutput("we_vs_iq_reset", int'(iq_reset), 0);
      if (sb.size() == 0) begin
        checkOutput("unexpected_push", int'(iq_we), 0);
      end else begin
        mp = sb.pop_front();
        checkOutput("push_count", int'(iq_copy_count), int'(mp.cnt));
        checkOutput("push_cache", int'(iq_cache_addr), int'(mp.cache));
        checkOutput("push_mem", int'(iq_main_mem_addr), int'(mp.mem));
        checkOutput("push_op", int'(iq_op), int'(mp.op));
        checkOutput("push_type", int'(iq_instr_type), int'(mp.typ));
      end
    end
  end

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_instr_type = 2'd0; in_repeat = 8'd0; in_op = 9'd0;
    in_cache_addr = 11'd0; in_d_cache_addr = 11'd0;
    in_main_mem_addr = 7'd0; in_d_main_mem_addr = 7'd0;
    iq_stall_push = 1'b0; iq_needs_reset = 1'b0;
    iq_empty = 1'b1; exec_idle = 1'b1;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    checkOutput("reset_in_ready", int'(in_ready), 1);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_iq_we", int'(iq_we), 0);
    checkOutput("reset_iq_reset", int'(iq_reset), 0);
    checkOutput("reset_cache", int'(iq_cache_addr), 0);
    tick();

    // Three groups without stalls; ready returns on the fourth cycle
    applyStimulus(2'd1, 40, 9'h1A5, 100, 3, 5, 1);
    @(negedge clk);
    checkOutput("t1_ready_low", int'(in_ready), 0);
    tick(); tick();
    @(negedge clk);
    checkOutput("t1_ready_low_c3", int'(in_ready), 0);
    tick();
    @(negedge clk);
    checkOutput("t1_ready_back", int'(in_ready), 1);
    tick();

    // Stall during the second push
    applyStimulus(2'd2, 20, 9'h033, 10, 2, 0, 3);
    tick();
    iq_stall_push = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("t2_stall_we", int'(iq_we), 0);
      checkOutput("t2_stall_count", int'(iq_copy_count), 4);
      checkOutput("t2_stall_cache", int'(iq_cache_addr), 42);
      tick();
    end
    iq_stall_push = 1'b0;
    waitIdle("t2_idle");

    // Refresh after the first of three groups
    iq_empty = 1'b0; exec_idle = 1'b0;
    applyStimulus(2'd0, 40, 9'h07F, 100, 3, 5, 1);
    tick();
    iq_needs_reset = 1'b1;
    @(negedge clk);
    checkOutput("t3_no_push", int'(iq_we), 0);
    tick();
    @(negedge clk);
    checkOutput("t3_drain_busy", int'(busy), 1);
    checkOutput("t3_drain_no_reset", int'(iq_reset), 0);
    tick();
    iq_empty = 1'b1; exec_idle = 1'b1;
    high_cycles = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (iq_reset) begin
        high_cycles++;
        iq_needs_reset = 1'b0;
      end
    end
    checkOutput("t3_reset_len", high_cycles, 2);
    checkOutput("t3_needs_cleared", int'(iq_needs_reset), 0);
    tick();
    waitIdle("t3_idle");

    // Cache address wrap, then a zero-repeat no-op
    applyStimulus(2'd1, 16, 9'h100, 2040, 1, 0, 0);
    waitIdle("t4_idle");
    checkOutput("t4_wrap_base", int'(iq_cache_addr), 8);
    applyStimulus(2'd1, 0, 9'h001, 5, 1, 1, 1);
    @(negedge clk);
    checkOutput("t4_noop_ready", int'(in_ready), 1);
    checkOutput("t4_noop_busy", int'(busy), 0);
    tick();

    // Global reset in the middle of an instruction
    applyStimulus(2'd2, 40, 9'h055, 300, 7, 10, 2);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete();
    @(negedge clk);
    checkOutput("t5_ready", int'(in_ready), 1);
    checkOutput("t5_we", int'(iq_we), 0);
    checkOutput("t5_iq_reset", int'(iq_reset), 0);
    checkOutput("t5_busy", int'(busy), 0);
    repeat (4) tick();

    checkOutput("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
